// File: rtl/instruction_loader_rom_pkg.sv
// Shared types and constants for the instruction loader ROM.
package loader_pkg;

   typedef logic [7:0] byte_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

   localparam byte_t NOP_INSTR_DEFAULT = 8'h00;

endpackage

// File: rtl/instruction_loader_rom_if.sv
// Program-byte load port: valid/ready handshake with a last-byte qualifier.
interface instruction_loader_rom_if;
   import loader_pkg::*;

   logic  load_valid;
   byte_t load_data;
   logic  load_last;
   logic  load_ready;

   modport master (output load_valid, load_data, load_last, input load_ready);
   modport slave  (input load_valid, load_data, load_last, output load_ready);

endinterface

// File: rtl/instruction_loader_rom_instr_ram.sv
// Single-port instruction RAM, synchronous write and synchronous read.
module instr_ram
   import loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clock,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  byte_t                 wdata,
   output byte_t                 rdata
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   byte_t mem [DEPTH];

   always_ff @(posedge clock) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/instruction_loader_rom.sv
// Loads a program byte stream into instruction RAM, then serves fetches in RUN.
// Optional LOADER_CHECKSUM_EN adds a modulo-256 checksum of accepted bytes.
//
//   state | meaning
//   IDLE  | after clear; next edge enters LOAD with pointer/length cleared
//   LOAD  | accepting program bytes until load_last or run_request
//   RUN   | serving instruction fetches; left only through clear
module instruction_loader_rom
   import loader_pkg::*;
#(
   parameter int    ADDR_WIDTH = 8,
   parameter byte_t NOP_INSTR  = NOP_INSTR_DEFAULT
) (
   input  logic                  clock,
   input  logic                  clear,
   instruction_loader_rom_if.slave load,
   input  logic                  run_request,
   input  logic [ADDR_WIDTH-1:0] read_address,
   output byte_t                 instruction,
   output logic                  running,
   output logic [ADDR_WIDTH:0]   program_length,
   output logic                  overflow
`ifdef LOADER_CHECKSUM_EN
   ,
   output byte_t                 checksum,
   output logic                  checksum_valid
`endif
);

   localparam logic [ADDR_WIDTH:0] LAST_SLOT = {1'b0, {ADDR_WIDTH{1'b1}}};

   state_t                state;
   logic [ADDR_WIDTH:0]   wr_ptr;
   logic                  ready_q;
   logic                  fetch_hit;
   logic                  full;
   logic                  accept;
   logic                  in_range;
   logic [ADDR_WIDTH-1:0] ram_addr;
   byte_t                 ram_rdata;

   assign full     = wr_ptr[ADDR_WIDTH];
   assign accept   = (state == LOAD) && load.load_valid && ready_q;
   assign in_range = {1'b0, read_address} < wr_ptr;
   // The single RAM port is shared: write pointer while loading, fetch address in RUN.
   assign ram_addr = (state == RUN) ? read_address : wr_ptr[ADDR_WIDTH-1:0];

   instr_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
      .clock (clock),
      .we    (accept),
      .addr  (ram_addr),
      .wdata (load.load_data),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clock) begin
      if (clear) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         ready_q   <= 1'b0;
         running   <= 1'b0;
         overflow  <= 1'b0;
         fetch_hit <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state     <= LOAD;
               wr_ptr    <= '0;
               ready_q   <= 1'b1;
               fetch_hit <= 1'b0;
            end
            LOAD: begin
               fetch_hit <= 1'b0;
               if (accept) begin
                  wr_ptr <= wr_ptr + 1'b1;
               end
               if (load.load_valid && full) begin
                  overflow <= 1'b1;
               end
               if ((load.load_valid && load.load_last) || run_request) begin
                  state   <= RUN;
                  ready_q <= 1'b0;
                  running <= 1'b1;
               end else if (accept && (wr_ptr == LAST_SLOT)) begin
                  ready_q <= 1'b0;
               end
            end
            RUN: begin
               fetch_hit <= in_range;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // The RAM output is already registered; fetch_hit masks it to NOP out of range or outside RUN.
   assign instruction    = fetch_hit ? ram_rdata : NOP_INSTR;
   assign program_length = wr_ptr;
   assign load.load_ready = ready_q;

`ifdef LOADER_CHECKSUM_EN
   always_ff @(posedge clock) begin
      if (clear || (state == IDLE)) begin
         checksum <= '0;
      end else if (accept) begin
         checksum <= checksum + load.load_data;
      end
   end

   assign checksum_valid = running;
`endif

endmodule
